// File: rtl/five_stage_memory_arbiter_if.sv
// Bus bundle between the five-stage core, the memory arbiter and the unified memory.
//   fetch side : i_read, i_address -> ; <- i_ready, i_valid, i_data, i_address_out
//   data side  : d_read, d_write, d_byte_en, d_address, d_data_in -> ;
//                <- d_ready, d_valid, d_data, d_address_out
//   memory side: <- mem_read, mem_write, mem_byte_en, mem_address, mem_data_out ;
//                mem_ready, mem_valid, mem_data_in, mem_address_in ->
//   status     : unexpected_resp (sticky error flag from the arbiter)
// The arbiter connects through modport slave; the environment (core + memory)
// connects through modport master.
interface five_stage_memory_arbiter_if #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BYTES    = DATA_WIDTH / 8
);
  logic                    i_read;
  logic [ADDRESS_BITS-1:0] i_address;
  logic                    i_ready;
  logic                    i_valid;
  logic [DATA_WIDTH-1:0]   i_data;
  logic [ADDRESS_BITS-1:0] i_address_out;

  logic                    d_read;
  logic                    d_write;
  logic [NUM_BYTES-1:0]    d_byte_en;
  logic [ADDRESS_BITS-1:0] d_address;
  logic [DATA_WIDTH-1:0]   d_data_in;
  logic                    d_ready;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   d_data;
  logic [ADDRESS_BITS-1:0] d_address_out;

  logic                    mem_read;
  logic                    mem_write;
  logic [NUM_BYTES-1:0]    mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic [ADDRESS_BITS-1:0] mem_address_in;

  logic                    unexpected_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_byte_en, d_address, d_data_in,
           mem_ready, mem_valid, mem_data_in, mem_address_in,
    output i_ready, i_valid, i_data, i_address_out,
           d_ready, d_valid, d_data, d_address_out,
           mem_read, mem_write, mem_byte_en, mem_address, mem_data_out,
           unexpected_resp
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_byte_en, d_address, d_data_in,
           mem_ready, mem_valid, mem_data_in, mem_address_in,
    input  i_ready, i_valid, i_data, i_address_out,
           d_ready, d_valid, d_data, d_address_out,
           mem_read, mem_write, mem_byte_en, mem_address, mem_data_out,
           unexpected_resp
  );
endinterface

// File: rtl/five_stage_memory_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   scan         : enables the per-cycle debug display inside the scan window
//   bus          : five_stage_memory_arbiter_if.slave (fetch, data, memory buses
//                  and the sticky unexpected_resp flag)
// Grants are combinational (zero-cycle issue). Data wins by default; after
// DATA_BURST_MAX data grants while fetch waits, fetch is forced through.
// Reads push the requester ID (0 fetch, 1 data) into an in-order ID FIFO so
// responses can be steered back; writes are not tracked.
// Optional macro ARB_ROUND_ROBIN_EN: replaces the starvation counter with
// alternating priority (data first after reset).
module five_stage_memory_arbiter #(
  parameter int CORE            = 0,
  parameter int ADDRESS_BITS    = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_BYTES       = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_BURST_MAX  = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           scan,
  five_stage_memory_arbiter_if.slave     bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FULL = 2'd2
  } fifo_state_t;

  fifo_state_t                state_r;
  logic [CW-1:0]              fifo_count_r;
  logic [CW-1:0]              count_next_s;
  logic [PW-1:0]              wr_ptr_r;
  logic [PW-1:0]              rd_ptr_r;
  logic [MAX_OUTSTANDING-1:0] id_mem_r;
  logic                       unexpected_r;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       head_id_s;
  logic                       pop_s;
  logic                       push_s;
  logic                       can_issue_s;
  logic                       d_req_s;
  logic                       fetch_wins_s;
  logic                       grant_i_s;
  logic                       grant_d_s;
  logic [31:0]                prio_view_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic fetch_prio_r;

  // Alternating priority: whoever was granted last yields to the other side.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_prio_r <= 1'b0;
    end else if (grant_d_s) begin
      fetch_prio_r <= 1'b1;
    end else if (grant_i_s) begin
      fetch_prio_r <= 1'b0;
    end else begin
      fetch_prio_r <= fetch_prio_r;
    end
  end

  assign fetch_wins_s = bus.i_read & fetch_prio_r;
  assign prio_view_s  = 32'(fetch_prio_r);
`else
  localparam int SW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [SW-1:0] BURST_CNT = SW'(DATA_BURST_MAX);
  localparam logic [SW-1:0] ONE_ST    = SW'(1);
  logic [SW-1:0] starve_r;

  // Count data grants that overtook a waiting fetch; saturates at the burst limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_r <= {SW{1'b0}};
    end else if (!bus.i_read || grant_i_s) begin
      starve_r <= {SW{1'b0}};
    end else if (grant_d_s && (starve_r != BURST_CNT)) begin
      starve_r <= starve_r + ONE_ST;
    end else begin
      starve_r <= starve_r;
    end
  end

  assign fetch_wins_s = bus.i_read & (starve_r == BURST_CNT);
  assign prio_view_s  = 32'(starve_r);
`endif

  // Grant decision and FIFO bookkeeping for the current cycle.
  always_comb begin
    fifo_empty_s = (state_r == ST_IDLE);
    fifo_full_s  = (state_r == ST_FULL);
    head_id_s    = id_mem_r[rd_ptr_r];
    pop_s        = bus.mem_valid & ~fifo_empty_s;
    // A full FIFO can still accept a new read when a response frees a slot now.
    can_issue_s  = bus.mem_ready & (~fifo_full_s | pop_s);
    d_req_s      = bus.d_read | bus.d_write;
    grant_d_s    = can_issue_s & d_req_s & ~fetch_wins_s;
    grant_i_s    = can_issue_s & bus.i_read & ~grant_d_s;
    // Read+write together is a store: nothing comes back, so nothing is pushed.
    push_s       = grant_i_s | (grant_d_s & ~bus.d_write);
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count_r + ONE_CNT;
      2'b01:   count_next_s = fifo_count_r - ONE_CNT;
      default: count_next_s = fifo_count_r;
    endcase
  end

  // ID FIFO storage, occupancy FSM and the sticky unexpected-response flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fifo_count_r <= {CW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      id_mem_r     <= {MAX_OUTSTANDING{1'b0}};
      unexpected_r <= 1'b0;
    end else begin
      if (push_s) begin
        id_mem_r[wr_ptr_r] <= grant_d_s;
        wr_ptr_r           <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      if (bus.mem_valid && fifo_empty_s) begin
        unexpected_r <= 1'b1;
      end
      fifo_count_r <= count_next_s;
      if (count_next_s == {CW{1'b0}}) begin
        state_r <= ST_IDLE;
      end else if (count_next_s == MAX_CNT) begin
        state_r <= ST_FULL;
      end else begin
        state_r <= ST_BUSY;
      end
    end
  end

  assign bus.i_ready         = grant_i_s;
  assign bus.d_ready         = grant_d_s;
  assign bus.mem_read        = grant_i_s | (grant_d_s & ~bus.d_write);
  assign bus.mem_write       = grant_d_s & bus.d_write;
  assign bus.mem_address     = grant_d_s ? bus.d_address :
                               (grant_i_s ? bus.i_address : {ADDRESS_BITS{1'b0}});
  assign bus.mem_byte_en     = (grant_d_s & bus.d_write) ? bus.d_byte_en :
                               ((grant_i_s | grant_d_s) ? {NUM_BYTES{1'b1}} : {NUM_BYTES{1'b0}});
  assign bus.mem_data_out    = (grant_d_s & bus.d_write) ? bus.d_data_in : {DATA_WIDTH{1'b0}};
  assign bus.i_valid         = pop_s & ~head_id_s;
  assign bus.d_valid         = pop_s & head_id_s;
  assign bus.i_data          = bus.mem_data_in;
  assign bus.d_data          = bus.mem_data_in;
  assign bus.i_address_out   = bus.mem_address_in;
  assign bus.d_address_out   = bus.mem_address_in;
  assign bus.unexpected_resp = unexpected_r;

  int cycle_r;

  // Free-running cycle counter that defines the scan display window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_r <= 32'sd0;
    end else begin
      cycle_r <= cycle_r + 32'sd1;
    end
  end

`ifndef SYNTHESIS
  // Debug trace of arbitration state while scan is enabled.
  always_ff @(posedge clock) begin
    if (!reset && scan && (cycle_r >= SCAN_CYCLES_MIN) && (cycle_r <= SCAN_CYCLES_MAX)) begin
      $display("[scan core %0d] cycle %0d fifo_count %0d head %0d prio %0d grant_i %0b grant_d %0b",
               CORE, cycle_r, fifo_count_r, head_id_s, prio_view_s, grant_i_s, grant_d_s);
    end
  end
`endif
endmodule

// File: tb/tb_five_stage_memory_arbiter.sv
// Self-checking bench for five_stage_memory_arbiter (default build: data priority
// with a starvation guard of DATA_BURST_MAX).
module tb_five_stage_memory_arbiter;
  localparam int AB    = 20;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int MAXO  = 4;
  localparam int BURST = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset;
  logic scan;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Environment memory: addresses it has accepted for reading and when.
  logic [AB-1:0] mq_addr[$];
  int            mq_cyc[$];

  five_stage_memory_arbiter_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .NUM_BYTES(NB)) bus();

  five_stage_memory_arbiter #(
    .CORE(0), .ADDRESS_BITS(AB), .DATA_WIDTH(DW), .NUM_BYTES(NB),
    .MAX_OUTSTANDING(MAXO), .DATA_BURST_MAX(BURST),
    .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock(clock), .reset(reset), .scan(scan), .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] word(input logic [AB-1:0] a);
    return KEY ^ {12'h000, a};
  endfunction

  task automatic idle_inputs;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_byte_en = '0;
    bus.d_address = '0; bus.d_data_in = '0;
    bus.mem_ready = 1'b0; bus.mem_valid = 1'b0;
    bus.mem_data_in = '0; bus.mem_address_in = '0;
    scan = 1'b0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq_addr.delete();
    mq_cyc.delete();
  endtask

  // Present the oldest accepted read once it is at least lat cycles old.
  task automatic mem_present(input int cyc, input int lat);
    if (mq_addr.size() > 0 && mq_cyc[0] + lat <= cyc) begin
      bus.mem_valid = 1'b1; bus.mem_address_in = mq_addr[0]; bus.mem_data_in = word(mq_addr[0]);
    end else begin
      bus.mem_valid = 1'b0; bus.mem_address_in = '0; bus.mem_data_in = '0;
    end
  endtask

  // Memory side of the clock edge: retire the presented response, accept a new read.
  task automatic mem_accept(input int cyc);
    if (bus.mem_valid && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
    end
    if (bus.mem_read) begin
      mq_addr.push_back(bus.mem_address);
      mq_cyc.push_back(cyc);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.i_ready, bus.d_ready, bus.i_valid, bus.d_valid, bus.mem_read, bus.mem_write,
         bus.unexpected_resp} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000", {bus.i_ready, bus.d_ready,
               bus.i_valid, bus.d_valid, bus.mem_read, bus.mem_write, bus.unexpected_resp});
    end
    tests_run++;
    if (dut.fifo_count_r !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", dut.fifo_count_r);
    end
    tick();
  endtask

  task automatic test_fetch_stream;
    int n = 0;
    int nresp = 0;
    bit d_seen = 1'b0;
    apply_reset();
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.i_read = (n < 4);
      bus.i_address = AB'(n * 4);
      mem_present(c, 2);
      #1;
      tests_run++;
      if (bus.i_ready !== (n < 4) || bus.mem_read !== (n < 4) ||
          (n < 4 && bus.mem_address !== AB'(n * 4))) begin
        tests_failed++;
        $display("FAIL fetch_issue c%0d: got ready %b read %b addr %h expected ready %b addr %h",
                 c, bus.i_ready, bus.mem_read, bus.mem_address, (n < 4), AB'(n * 4));
      end
      if (bus.mem_valid) begin
        tests_run++;
        if (bus.i_valid !== 1'b1 || bus.i_address_out !== AB'(nresp * 4) ||
            bus.i_data !== word(AB'(nresp * 4))) begin
          tests_failed++;
          $display("FAIL fetch_resp c%0d: got valid %b addr %h data %h expected 1 %h %h",
                   c, bus.i_valid, bus.i_address_out, bus.i_data, AB'(nresp * 4), word(AB'(nresp * 4)));
        end
        nresp++;
      end
      if (bus.d_valid) d_seen = 1'b1;
      mem_accept(c);
      if (bus.i_ready) n++;
      tick();
    end
    tests_run++;
    if (nresp != 4 || d_seen) begin
      tests_failed++;
      $display("FAIL fetch_totals: got %0d responses d_valid_seen %b expected 4 and 0", nresp, d_seen);
    end
  endtask

  task automatic test_contention;
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.i_read = 1'b1; bus.i_address = AB'(32'h40);
    bus.d_read = 1'b1; bus.d_address = AB'(32'h80);
    for (int k = 0; k < 10; k++) begin
      bit exp_i;
      exp_i = (k % 5 == 4);
      mem_present(k, 1);
      #1;
      tests_run++;
      if ({bus.i_ready, bus.d_ready} !== {exp_i, ~exp_i} ||
          bus.mem_address !== (exp_i ? AB'(32'h40) : AB'(32'h80))) begin
        tests_failed++;
        $display("FAIL contention k%0d: got i %b d %b addr %h expected i %b d %b",
                 k, bus.i_ready, bus.d_ready, bus.mem_address, exp_i, ~exp_i);
      end
      mem_accept(k);
      tick();
    end
  endtask

  task automatic test_fifo_full;
    int n = 0;
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.d_read = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bit exp_rdy;
      exp_rdy = (c < 4) || (c == 6);
      bus.d_address = AB'(32'h10 + n * 4);
      if (c == 6) mem_present(c, 0);
      else bus.mem_valid = 1'b0;
      #1;
      tests_run++;
      if (bus.d_ready !== exp_rdy || (c == 6 && (bus.d_valid !== 1'b1 || bus.d_address_out !== AB'(32'h10)))) begin
        tests_failed++;
        $display("FAIL fifo_full c%0d: got ready %b valid %b addr %h expected ready %b",
                 c, bus.d_ready, bus.d_valid, bus.d_address_out, exp_rdy);
      end
      mem_accept(c);
      if (bus.d_ready) n++;
      tick();
    end
    tests_run++;
    if (dut.fifo_count_r !== 3'd4) begin
      tests_failed++;
      $display("FAIL fifo_full_count: got %0d expected 4", dut.fifo_count_r);
    end
    bus.d_read = 1'b0;
    for (int c = 7; c < 11; c++) begin
      mem_present(c, 0);
      #1;
      mem_accept(c);
      tick();
    end
    bus.mem_valid = 1'b0;
    #1;
    tests_run++;
    if (dut.fifo_count_r !== 3'd0) begin
      tests_failed++;
      $display("FAIL fifo_drain_count: got %0d expected 0", dut.fifo_count_r);
    end
  endtask

  task automatic test_ordering;
    logic [AB-1:0] exp_addr[$];
    bit            exp_id[$];
    int            nresp = 0;
    apply_reset();
    bus.mem_ready = 1'b1;
    exp_addr = '{AB'(32'h100), AB'(32'h200), AB'(32'h104)};
    exp_id   = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 9; c++) begin
      bus.i_read = (c == 0) || (c == 2);
      bus.i_address = (c == 0) ? AB'(32'h100) : AB'(32'h104);
      bus.d_read = (c == 1);
      bus.d_address = AB'(32'h200);
      mem_present(c, 3);
      #1;
      if (c < 3) begin
        tests_run++;
        if ({bus.i_ready, bus.d_ready} !== {exp_id[c] == 1'b0, exp_id[c] == 1'b1}) begin
          tests_failed++;
          $display("FAIL order_issue c%0d: got i %b d %b", c, bus.i_ready, bus.d_ready);
        end
      end
      if (bus.mem_valid && nresp < 3) begin
        tests_run++;
        if ({bus.i_valid, bus.d_valid} !== {!exp_id[nresp], exp_id[nresp]} ||
            (exp_id[nresp] && bus.d_data !== word(exp_addr[nresp])) ||
            (!exp_id[nresp] && bus.i_address_out !== exp_addr[nresp])) begin
          tests_failed++;
          $display("FAIL order_resp %0d: got i %b d %b d_data %h i_addr %h expected id %0d addr %h",
                   nresp, bus.i_valid, bus.d_valid, bus.d_data, bus.i_address_out,
                   exp_id[nresp], exp_addr[nresp]);
        end
        nresp++;
      end
      mem_accept(c);
      tick();
    end
    tests_run++;
    if (nresp != 3) begin
      tests_failed++;
      $display("FAIL order_count: got %0d responses expected 3", nresp);
    end
  endtask

  task automatic test_store;
    apply_reset();
    bus.mem_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      bus.d_write = 1'b1; bus.d_read = (s == 1);
      bus.d_byte_en = 4'b0011; bus.d_data_in = 32'hDEAD_BEEF;
      bus.d_address = AB'(32'h300 + s * 4);
      #1;
      tests_run++;
      if ({bus.d_ready, bus.mem_write, bus.mem_read} !== 3'b110 || bus.mem_byte_en !== 4'b0011 ||
          bus.mem_data_out !== 32'hDEAD_BEEF || bus.mem_address !== AB'(32'h300 + s * 4)) begin
        tests_failed++;
        $display("FAIL store %0d: got rdy/wr/rd %b be %b data %h addr %h", s,
                 {bus.d_ready, bus.mem_write, bus.mem_read}, bus.mem_byte_en, bus.mem_data_out, bus.mem_address);
      end
      mem_accept(s);
      tick();
    end
    idle_inputs();
    bus.mem_ready = 1'b1;
    for (int c = 2; c < 5; c++) begin
      mem_present(c, 0);
      #1;
      tests_run++;
      if (bus.d_valid !== 1'b0 || dut.fifo_count_r !== 3'd0) begin
        tests_failed++;
        $display("FAIL store_after c%0d: got d_valid %b count %0d expected 0 0", c, bus.d_valid, dut.fifo_count_r);
      end
      tick();
    end
  endtask

  task automatic test_unexpected_and_reset;
    apply_reset();
    bus.mem_valid = 1'b1; bus.mem_address_in = AB'($urandom);
    #1;
    tests_run++;
    if ({bus.i_valid, bus.d_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL unexp_drop: got i %b d %b expected 0 0", bus.i_valid, bus.d_valid);
    end
    tick();
    bus.mem_valid = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.unexpected_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL unexp_sticky: got %b expected 1", bus.unexpected_resp);
    end
    // Build up starvation, then reset with both requesters still asking.
    bus.mem_ready = 1'b1; bus.i_read = 1'b1; bus.d_read = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq_addr.delete();
    mq_cyc.delete();
    #1;
    tests_run++;
    if (bus.unexpected_resp !== 1'b0 || dut.fifo_count_r !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_clear: got unexp %b count %0d expected 0 0", bus.unexpected_resp, dut.fifo_count_r);
    end
    for (int k = 0; k < 5; k++) begin
      mem_present(k, 1);
      #1;
      tests_run++;
      if (bus.i_ready !== (k == 4)) begin
        tests_failed++;
        $display("FAIL reset_starve k%0d: got i_ready %b expected %b", k, bus.i_ready, (k == 4));
      end
      mem_accept(k);
      tick();
    end
  endtask

  task automatic test_random;
    bit            ids[$];
    int            starve = 0;
    bit            unexp = 1'b0;
    bit            i_pend = 1'b0, d_pend = 1'b0;
    int            d_kind = 0;
    logic [AB-1:0] i_a = '0, d_a = '0;
    logic [NB-1:0] d_be = '0;
    logic [DW-1:0] d_wd = '0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bit pop, full, can, dw, gd, gi, mrd;
      if (!i_pend && $urandom_range(0, 99) < 60) begin
        i_pend = 1'b1; i_a = AB'($urandom) & 20'hFFFFC;
      end
      if (!d_pend && $urandom_range(0, 99) < 50) begin
        d_pend = 1'b1; d_kind = int'($urandom_range(0, 2));
        d_a = AB'($urandom) & 20'hFFFFC; d_be = NB'($urandom); d_wd = $urandom;
      end
      bus.i_read = i_pend; bus.i_address = i_a;
      bus.d_read = d_pend && (d_kind != 1); bus.d_write = d_pend && (d_kind != 0);
      bus.d_address = d_a; bus.d_byte_en = d_be; bus.d_data_in = d_wd;
      bus.mem_ready = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 50) mem_present(c, 1);
      else mem_present(c, 1000000);
      #1;
      dw   = d_pend && (d_kind != 0);
      pop  = bus.mem_valid && ids.size() > 0;
      full = (ids.size() == MAXO);
      can  = bus.mem_ready && (!full || pop);
      gd   = can && d_pend && !(i_pend && starve == BURST);
      gi   = can && i_pend && !gd;
      mrd  = gi || (gd && !dw);
      tests_run++;
      if ({bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write} !== {gi, gd, mrd, gd && dw} ||
          ((gi || gd) && bus.mem_address !== (gd ? d_a : i_a)) ||
          (gd && dw && (bus.mem_byte_en !== d_be || bus.mem_data_out !== d_wd))) begin
        tests_failed++;
        $display("FAIL rand_grant c%0d: got i/d/rd/wr %b addr %h expected %b addr %h", c,
                 {bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write}, bus.mem_address,
                 {gi, gd, mrd, gd && dw}, (gd ? d_a : i_a));
      end
      tests_run++;
      if ({bus.i_valid, bus.d_valid} !== {pop && !ids[0], pop && ids[0]} ||
          (pop && (bus.i_data !== bus.mem_data_in || bus.d_address_out !== bus.mem_address_in)) ||
          bus.unexpected_resp !== unexp) begin
        tests_failed++;
        $display("FAIL rand_resp c%0d: got i %b d %b unexp %b expected %b %b %b", c,
                 bus.i_valid, bus.d_valid, bus.unexpected_resp, pop && !ids[0], pop && ids[0], unexp);
      end
      if (bus.mem_valid && ids.size() == 0) unexp = 1'b1;
      if (pop) void'(ids.pop_front());
      if (gi) ids.push_back(1'b0);
      if (gd && !dw) ids.push_back(1'b1);
      if (!i_pend || gi) starve = 0;
      else if (gd) starve++;
      if (gi) i_pend = 1'b0;
      if (gd) d_pend = 1'b0;
      mem_accept(c);
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_fetch_stream();
    test_contention();
    test_fifo_full();
    test_ordering();
    test_store();
    test_unexpected_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
